// File: rtl/sargantana_icache_refill.sv
// Icache miss handler: captures a lookup miss, picks a victim way, issues a
// single line request to L2, assembles the returned beats into a line and
// writes line + tag into the victim way, then pulses refill_done_o so fetch
// replays the lookup.
// Optional: define ICACHE_REFILL_PERF_CNT_EN to add the miss_cnt_o counter.
module sargantana_icache_refill #(
  parameter int unsigned ICACHE_N_WAY = 4,
  parameter int unsigned TAG_WIDHT    = 20,
  parameter int unsigned IDX_WIDTH    = 6,
  parameter int unsigned WAY_WIDHT    = 256,
  parameter int unsigned BEAT_WIDTH   = 64
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           miss_i,
  input  logic [TAG_WIDHT-1:0]           miss_tag_i,
  input  logic [IDX_WIDTH-1:0]           miss_idx_i,
  input  logic [ICACHE_N_WAY-1:0]        way_valid_bits_i,
  input  logic                           flush_i,
  output logic                           l2_req_valid_o,
  input  logic                           l2_req_ready_i,
  output logic [TAG_WIDHT+IDX_WIDTH-1:0] l2_req_addr_o,
  input  logic                           l2_rsp_valid_i,
  input  logic [BEAT_WIDTH-1:0]          l2_rsp_data_i,
  output logic                           l2_rsp_ready_o,
  output logic                           wr_en_o,
  output logic [ICACHE_N_WAY-1:0]        wr_way_o,
  output logic [IDX_WIDTH-1:0]           wr_idx_o,
  output logic [TAG_WIDHT-1:0]           wr_tag_o,
  output logic [WAY_WIDHT-1:0]           wr_data_o,
  output logic                           busy_o,
  output logic                           refill_done_o
`ifdef ICACHE_REFILL_PERF_CNT_EN
  ,
  output logic [31:0]                    miss_cnt_o
`endif
);

  localparam int unsigned NBEATS    = WAY_WIDHT / BEAT_WIDTH;
  localparam int unsigned CNT_W     = $clog2(NBEATS);
  localparam int unsigned WAY_IDX_W = $clog2(ICACHE_N_WAY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RSP   = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [TAG_WIDHT-1:0]    tag_q;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [ICACHE_N_WAY-1:0] way_q;
  logic                    full_q;
  logic                    kill_q;
  logic [WAY_IDX_W-1:0]    rr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [WAY_WIDHT-1:0]    line_q;

  logic                    capture;
  logic                    beat_acc;
  logic                    write_ok;
  logic                    set_full;
  logic                    found;
  logic [ICACHE_N_WAY-1:0] victim_oh;

  // Victim: lowest invalid way, otherwise the round-robin pointer.
  always_comb begin
    victim_oh = '0;
    found     = 1'b0;
    set_full  = &way_valid_bits_i;
    for (int i = 0; i < ICACHE_N_WAY; i++) begin
      if (!way_valid_bits_i[i] && !found) begin
        victim_oh[i] = 1'b1;
        found        = 1'b1;
      end
    end
    if (!found) victim_oh = ICACHE_N_WAY'(1) << rr_q;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    beat_acc = 1'b0;
    write_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_i && !flush_i) begin
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (l2_req_ready_i) state_d = RSP;
      end
      RSP: begin
        if (l2_rsp_valid_i) begin
          beat_acc = 1'b1;
          if (cnt_q == CNT_W'(NBEATS - 1)) state_d = WRITE;
        end
      end
      WRITE: begin
        write_ok = !kill_q && !flush_i;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and refill datapath.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      way_q   <= '0;
      full_q  <= 1'b0;
      kill_q  <= 1'b0;
      rr_q    <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        tag_q  <= miss_tag_i;
        idx_q  <= miss_idx_i;
        way_q  <= victim_oh;
        full_q <= set_full;
      end
      if (beat_acc) begin
        line_q[32'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] <= l2_rsp_data_i;
        cnt_q <= (cnt_q == CNT_W'(NBEATS - 1)) ? '0 : cnt_q + CNT_W'(1);
      end
      if (state_d == IDLE) begin
        kill_q <= 1'b0;
      end else if (flush_i && (state_q == REQ || state_q == RSP)) begin
        kill_q <= 1'b1;
      end
      if (write_ok && full_q) rr_q <= rr_q + WAY_IDX_W'(1);
    end
  end

`ifdef ICACHE_REFILL_PERF_CNT_EN
  logic [31:0] miss_cnt_q;

  // Saturating count of accepted misses; survives flushes.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      miss_cnt_q <= '0;
    end else if (capture && (miss_cnt_q != '1)) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign miss_cnt_o = miss_cnt_q;
`endif

  // Outputs decoded from registered state; a flush in WRITE suppresses the write.
  assign l2_req_valid_o = (state_q == REQ);
  assign l2_req_addr_o  = (state_q == REQ) ? {tag_q, idx_q} : '0;
  assign l2_rsp_ready_o = (state_q == RSP);
  assign busy_o         = (state_q != IDLE);
  assign wr_en_o        = write_ok;
  assign refill_done_o  = write_ok;
  assign wr_way_o       = (state_q == WRITE) ? way_q  : '0;
  assign wr_idx_o       = (state_q == WRITE) ? idx_q  : '0;
  assign wr_tag_o       = (state_q == WRITE) ? tag_q  : '0;
  assign wr_data_o      = (state_q == WRITE) ? line_q : '0;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Directed bench for sargantana_icache_refill: a transaction-level model is
// compared against every output each cycle, plus literal checks at key points.
module tb_sargantana_icache_refill;

  localparam int NWAY   = 4;
  localparam int NBEATS = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         miss;
  logic [19:0]  miss_tag;
  logic [5:0]   miss_idx;
  logic [3:0]   vbits;
  logic         flush;
  logic         req_ready;
  logic         rsp_valid;
  logic [63:0]  rsp_data;

  logic         l2_req_valid_o;
  logic [25:0]  l2_req_addr_o;
  logic         l2_rsp_ready_o;
  logic         wr_en_o;
  logic [3:0]   wr_way_o;
  logic [5:0]   wr_idx_o;
  logic [19:0]  wr_tag_o;
  logic [255:0] wr_data_o;
  logic         busy_o;
  logic         refill_done_o;
`ifdef ICACHE_REFILL_PERF_CNT_EN
  logic [31:0]  miss_cnt_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sargantana_icache_refill dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .miss_i           (miss),
    .miss_tag_i       (miss_tag),
    .miss_idx_i       (miss_idx),
    .way_valid_bits_i (vbits),
    .flush_i          (flush),
    .l2_req_valid_o   (l2_req_valid_o),
    .l2_req_ready_i   (req_ready),
    .l2_req_addr_o    (l2_req_addr_o),
    .l2_rsp_valid_i   (rsp_valid),
    .l2_rsp_data_i    (rsp_data),
    .l2_rsp_ready_o   (l2_rsp_ready_o),
    .wr_en_o          (wr_en_o),
    .wr_way_o         (wr_way_o),
    .wr_idx_o         (wr_idx_o),
    .wr_tag_o         (wr_tag_o),
    .wr_data_o        (wr_data_o),
    .busy_o           (busy_o),
    .refill_done_o    (refill_done_o)
`ifdef ICACHE_REFILL_PERF_CNT_EN
    ,
    .miss_cnt_o       (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit           m_active, m_req_pend, m_writing, m_killed, m_full;
  int           m_got, m_rr, m_victim;
  logic [19:0]  m_tag;
  logic [5:0]   m_idx;
  logic [255:0] m_line;
  longint       m_cnt;

  always @(posedge clk) begin
    if (!rstn) begin
      m_active = 0; m_req_pend = 0; m_writing = 0; m_killed = 0;
      m_got = 0; m_rr = 0; m_cnt = 0;
    end else if (m_writing) begin
      if (!m_killed && !flush && m_full) m_rr = (m_rr + 1) % NWAY;
      m_writing = 0; m_active = 0; m_killed = 0;
    end else if (!m_active) begin
      if (miss && !flush) begin
        m_active = 1; m_req_pend = 1; m_got = 0;
        m_tag = miss_tag; m_idx = miss_idx;
        m_full = (vbits == 4'hF);
        m_victim = m_rr;
        for (int i = NWAY - 1; i >= 0; i--) if (vbits[i] == 1'b0) m_victim = i;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
    end else if (m_req_pend) begin
      if (flush) m_killed = 1;
      if (req_ready) m_req_pend = 0;
    end else begin
      if (flush) m_killed = 1;
      if (rsp_valid) begin
        m_line[m_got*64 +: 64] = rsp_data;
        m_got++;
        if (m_got == NBEATS) m_writing = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit wr;
      wr = m_active && m_writing;
      chk("busy",       busy_o,         m_active);
      chk("req_valid",  l2_req_valid_o, m_active && m_req_pend);
      chk("req_addr",   l2_req_addr_o,  (m_active && m_req_pend) ? {m_tag, m_idx} : 26'd0);
      chk("rsp_ready",  l2_rsp_ready_o, m_active && !m_req_pend && !m_writing);
      chk("wr_en",      wr_en_o,        wr && !m_killed && !flush);
      chk("done",       refill_done_o,  wr && !m_killed && !flush);
      chk("wr_way",     wr_way_o,       wr ? (4'b0001 << m_victim) : 4'd0);
      chk("wr_idx",     wr_idx_o,       wr ? m_idx : 6'd0);
      chk("wr_tag",     wr_tag_o,       wr ? m_tag : 20'd0);
      chk("wr_data",    wr_data_o,      wr ? m_line : 256'd0);
`ifdef ICACHE_REFILL_PERF_CNT_EN
      chk("miss_cnt",   miss_cnt_o,     m_cnt[31:0]);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] beat(input int k, input logic [63:0] seed);
    logic [3:0] n;
    n = 4'(k);
    return {16{n}} ^ seed;
  endfunction

  function automatic logic [255:0] mkline(input logic [63:0] seed);
    return {beat(3, seed), beat(2, seed), beat(1, seed), beat(0, seed)};
  endfunction

  task automatic refill(input logic [19:0] tag, input logic [5:0] idx, input logic [3:0] vb,
                        input int rdy_dly, input int flush_at, input bit flush_req,
                        input bit flush_wr, input logic [63:0] seed,
                        input logic [3:0] exp_way, input logic exp_en,
                        input logic [255:0] exp_data);
    miss = 1'b1; miss_tag = tag; miss_idx = idx; vbits = vb;
    cyc();
    miss = 1'b0; vbits = 4'h0;
    chk("lit_req_valid", l2_req_valid_o, 1'b1);
    chk("lit_req_addr",  l2_req_addr_o,  {tag, idx});
    for (int c = 0; c < rdy_dly; c++) begin
      rsp_valid = 1'b1; rsp_data = '1;
      flush = flush_req && (c == 0);
      cyc();
    end
    rsp_valid = 1'b0; flush = 1'b0; req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    for (int k = 0; k < NBEATS; k++) begin
      rsp_valid = 1'b1; rsp_data = beat(k, seed);
      cyc();
      rsp_valid = 1'b0;
      if (k == flush_at) begin
        flush = 1'b1;
        cyc();
        flush = 1'b0;
      end
    end
    flush = flush_wr;
    #1;
    chk("lit_wr_way",  wr_way_o,      exp_way);
    chk("lit_wr_en",   wr_en_o,       exp_en);
    chk("lit_done",    refill_done_o, exp_en);
    chk("lit_wr_data", wr_data_o,     exp_data);
    cyc();
    flush = 1'b0;
    chk("lit_idle_after", busy_o, 1'b0);
    chk("lit_done_pulse", refill_done_o, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; miss = 1'b0; miss_tag = '0; miss_idx = '0; vbits = '0;
    flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rstn = 1'b1;
    chk("lit_rst_busy",  busy_o,         1'b0);
    chk("lit_rst_req",   l2_req_valid_o, 1'b0);
    chk("lit_rst_wr_en", wr_en_o,        1'b0);
    chk("lit_rst_data",  wr_data_o,      256'd0);
    cyc();

    // Partially valid set: lowest invalid way (2), back-to-back beats.
    refill(20'h12345, 6'd5, 4'b1011, 0, -1, 0, 0, 64'h0, 4'b0100, 1'b1,
           {64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111, 64'h0});
    // Full sets walk the round-robin pointer.
    refill(20'h00AAA, 6'd1, 4'b1111, 0, -1, 0, 0, 64'hA5A5, 4'b0001, 1'b1, mkline(64'hA5A5));
    refill(20'h00BBB, 6'd2, 4'b1111, 0, -1, 0, 0, 64'hB0B0, 4'b0010, 1'b1, mkline(64'hB0B0));
    refill(20'h00CCC, 6'd3, 4'b1111, 0, -1, 0, 0, 64'hC0C0, 4'b0100, 1'b1, mkline(64'hC0C0));
    // Request held 5 cycles with stray beats that must be ignored.
    refill(20'hFFFFF, 6'd63, 4'b1111, 5, -1, 0, 0, 64'hDEAD, 4'b1000, 1'b1, mkline(64'hDEAD));
    // Flush after beat 1 with a gap: beats drained, no write, pointer unchanged.
    refill(20'h11111, 6'd7, 4'b1111, 0, 1, 0, 0, 64'h1234, 4'b0001, 1'b0, mkline(64'h1234));
    refill(20'h22222, 6'd8, 4'b1111, 0, -1, 0, 0, 64'h5678, 4'b0001, 1'b1, mkline(64'h5678));
    // Miss with flush in IDLE: no capture.
    miss = 1'b1; flush = 1'b1; vbits = 4'hF;
    cyc();
    miss = 1'b0; flush = 1'b0; vbits = 4'h0;
    chk("lit_idle_flush_busy", busy_o, 1'b0);
    cyc();
    // Flush while the request is stalled, then a flush in the write cycle.
    refill(20'h33333, 6'd9,  4'b1111, 2, -1, 1, 0, 64'h9999, 4'b0010, 1'b0, mkline(64'h9999));
    refill(20'h44444, 6'd10, 4'b1111, 0, -1, 0, 1, 64'h7777, 4'b0010, 1'b0, mkline(64'h7777));
    refill(20'h55555, 6'd11, 4'b1111, 0, -1, 0, 0, 64'h6666, 4'b0010, 1'b1, mkline(64'h6666));

    // Reset in the middle of the response phase.
    miss = 1'b1; miss_tag = 20'h66666; miss_idx = 6'd12; vbits = 4'hF;
    cyc();
    miss = 1'b0; vbits = 4'h0; req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rsp_valid = 1'b1; rsp_data = beat(k, 64'hF00D);
      cyc();
    end
    rsp_valid = 1'b0; rstn = 1'b0;
    cyc();
    chk("lit_midrst_busy", busy_o,         1'b0);
    chk("lit_midrst_rdy",  l2_rsp_ready_o, 1'b0);
    chk("lit_midrst_wr",   wr_en_o,        1'b0);
    rstn = 1'b1;
    cyc();
    refill(20'h77777, 6'd13, 4'b0111, 0, -1, 0, 0, 64'hBEEF, 4'b1000, 1'b1, mkline(64'hBEEF));
    refill(20'h88888, 6'd14, 4'b1111, 0, -1, 0, 0, 64'hCAFE, 4'b0001, 1'b1, mkline(64'hCAFE));
`ifdef ICACHE_REFILL_PERF_CNT_EN
    chk("lit_miss_cnt", miss_cnt_o, 32'd2);
`endif
    cyc();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_refill.md
Name: sargantana_icache_refill

Overview:
- Miss handler directly downstream of the icache tag/data checker.
- Consumes the lookup outcome: a miss means a valid lookup whose per-way hit vector is all zero.
- On a miss it captures tag and set index, picks a victim way, and issues one line request to L2.
- It then assembles the returned beats into a full line, writes the line plus tag into the selected way, and signals the fetch stage to replay the lookup.

Parameters:
- ICACHE_N_WAY, 4, number of ways; power of two, at least 2.
- TAG_WIDHT, 20, physical tag width.
- IDX_WIDTH, 6, set index width.
- WAY_WIDHT, 256, cache line width in bits.
- BEAT_WIDTH, 64, L2 response beat width. WAY_WIDHT/BEAT_WIDTH = NBEATS must be an integer of at least 2.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, synchronous, active-low.
- miss_i  in  1  lookup valid and no way hit.
- miss_tag_i  in  TAG_WIDHT  tag of the missing fetch (paddr).
- miss_idx_i  in  IDX_WIDTH  set index of the missing fetch.
- way_valid_bits_i  in  ICACHE_N_WAY  valid bits of the indexed set.
- flush_i  in  1  kill any in-flight refill.
- l2_req_valid_o  out  1  line request valid.
- l2_req_ready_i  in  1  L2 accepts request.
- l2_req_addr_o  out  TAG_WIDHT+IDX_WIDTH  line address, {tag, idx}.
- l2_rsp_valid_i  in  1  response beat valid.
- l2_rsp_data_i  in  BEAT_WIDTH  response beat.
- l2_rsp_ready_o  out  1  beat accept.
- wr_en_o  out  1  tag/data array write strobe.
- wr_way_o  out  ICACHE_N_WAY  one-hot victim way.
- wr_idx_o  out  IDX_WIDTH  set to write.
- wr_tag_o  out  TAG_WIDHT  tag to write; the way's valid bit is set by the write.
- wr_data_o  out  WAY_WIDHT  assembled line.
- busy_o  out  1  FSM not IDLE; fetch stalls while this is high.
- refill_done_o  out  1  one-cycle pulse; the fetch stage replays the lookup.

Behaviour:
- Clock and reset:
  - Single clock clk_i; reset rstn_i is synchronous and active-low.
  - Under reset: state IDLE; every output 0; round-robin pointer 0; beat counter 0; kill flag 0.
- States:
  - IDLE: miss_i=1 captures tag, idx and victim, then goes to REQ next cycle. miss_i is ignored in every other state; the producer holds the miss.
  - REQ: l2_req_valid_o=1 with the captured address. Valid stays high until l2_req_ready_i, then goes to RSP. Request latency is 1 cycle from miss_i.
  - RSP: l2_rsp_ready_o=1. Each l2_rsp_valid_i beat k (0-based, first beat k=0) is stored in line bits [k*BEAT_WIDTH +: BEAT_WIDTH]. The beat counter increments per beat; on beat NBEATS-1 the FSM goes to WRITE and the counter wraps to 0. Gaps between beats are allowed. l2_rsp_valid_i is ignored outside RSP.
  - WRITE: one cycle. wr_en_o=1 and refill_done_o=1 in the same cycle, then back to IDLE. The write and done strobe appear 1 cycle after the last beat.
- Victim selection (at capture):
  - If any way_valid_bits_i bit is 0, the lowest-index invalid way is chosen.
  - Otherwise the way is the round-robin pointer. The pointer increments, modulo ICACHE_N_WAY, only when a write to a full set completes.
- wr_way_o, wr_idx_o, wr_tag_o and wr_data_o are registered and stable from capture, or from the last beat for data, through WRITE. They read 0 when not in WRITE.
- Flush:
  - flush_i in IDLE: no effect.
  - flush_i in REQ: request is still held until accepted, as valid may not drop. The kill flag is set.
  - flush_i in RSP: the kill flag is set and the remaining beats are drained.
  - Kill flag set, or flush_i high, in WRITE: wr_en_o=0 and refill_done_o=0; the FSM still returns to IDLE and the round-robin pointer does not advance.
  - The kill flag clears on entry to IDLE.
- Simultaneous miss_i and flush_i in IDLE: the flush wins and no capture occurs.
- Reset mid-refill: immediate return to IDLE with no write. Outstanding L2 beats after reset are the L2 side's responsibility.

Optional Feature:
- Macro ICACHE_REFILL_PERF_CNT_EN.
- When defined, extra output port miss_cnt_o, 32 bits:
  - Counts accepted misses, i.e. IDLE captures.
  - Saturates at 0xFFFFFFFF.
  - Reset to 0; flush does not clear it.
- When undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Valid bits 4'b1011, miss_i with tag 0x12345, idx 5, ready immediate, beats 0x0..0/0x1..1/0x2..2/0x3..3 back-to-back -> l2_req_addr_o={0x12345,5} at t+1; wr_en_o 1 cycle after beat 3; wr_way_o=4'b0100; wr_data_o={beat3,beat2,beat1,beat0}; refill_done_o single pulse.
- Three misses to full sets (valid 4'b1111) -> wr_way_o 0001, 0010, 0100 in order.
- l2_req_ready_i held low 5 cycles -> l2_req_valid_o and l2_req_addr_o stable all 5 cycles; busy_o=1 throughout.
- flush_i pulsed after beat 1 -> beats 2 and 3 accepted; wr_en_o=0; refill_done_o=0; IDLE afterwards; the next full-set miss still uses the unchanged round-robin pointer.
- rstn_i low during RSP -> next cycle all outputs 0 and busy_o=0; a subsequent miss completes normally.
- With ICACHE_REFILL_PERF_CNT_EN defined, 3 misses including one flushed -> miss_cnt_o=3.
